// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the round-robin FIFO drain arbiter:
//   - arb_state_e : arbiter state encoding (IDLE / GRANT)
//   - clog2       : constant ceil(log2(value)) used to size counters/indices
//   - idx_width   : index width for N requesters, never narrower than 1 bit
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/fifo_rr_drain_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Returns the first set request bit found
// when searching last+1, last+2, ... with wrap modulo N.
// Ports:
//   req  [N]   request vector
//   last [SW]  index granted most recently (always < N)
//   any        at least one request bit is set
//   idx  [SW]  chosen index (0 when any = 0)
// ---------------------------------------------------------------------------
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] last,
  output logic          any,
  output logic [SW-1:0] idx
);

  localparam int IW = clog2(2 * N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [SW-1:0]  start;
  logic [IW-1:0]  pos;

  always_comb begin
    // Wrap happens at N, not at 2**SW, so the increment is explicit.
    start = (last == SW'(N - 1)) ? '0 : last + 1'b1;

    // Concatenating req with itself lets a plain offset act as a rotate:
    // rot[i] is the request that sits i places after 'start'.
    dbl = {req, req};
    rot = '0;
    pos = '0;
    for (int i = 0; i < N; i++) begin
      pos    = IW'(start) + IW'(i);
      rot[i] = dbl[pos];
    end

    any = |req;

    // Lowest set bit of the rotated vector wins; iterate downwards so the
    // last assignment is the lowest offset.
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        idx = SW'((int'(start) + i) % N);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_drain_arb.sv
// ---------------------------------------------------------------------------
// fifo_rr_drain_arb
// Round-robin drain scheduler for N first-word-fall-through FIFOs. Grants one
// eligible (non-empty, unmasked) FIFO, pops up to BURST words from it into a
// single-entry valid/ready output register, then rotates to the next FIFO.
//
// Ports:
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   empty_i    [N]     per-FIFO empty flag
//   r_data_i   [N*B]   per-FIFO read data, FIFO k at [k*B +: B]
//   mask_i     [N]     1 = FIFO not eligible for grant
//   rd_o       [N]     combinational pop strobe, at most one bit high
//   out_data   [B]     registered output word
//   out_src    [SW]    index of the FIFO that supplied out_data
//   out_valid          out_data/out_src hold a word
//   out_ready          consumer accepts when out_valid & out_ready
//   busy               high while a grant is held
//
// State   | Meaning
// --------+----------------------------------------------------------------
// IDLE    | arbitrate among eligible FIFOs; no pop in this state
// GRANT   | pop from gnt while eligible and the output slot is free
// ---------------------------------------------------------------------------
module fifo_rr_drain_arb
  import fifo_arb_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int B     = 8,
  parameter  int BURST = 4,
  localparam int SW    = idx_width(N),
  localparam int BW    = clog2(BURST + 1)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   empty_i,
  input  logic [N*B-1:0] r_data_i,
  input  logic [N-1:0]   mask_i,
  output logic [N-1:0]   rd_o,
  output logic [B-1:0]   out_data,
  output logic [SW-1:0]  out_src,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy
);

  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST - 1);
  localparam logic [SW-1:0] LAST_RST  = SW'(N - 1);

  arb_state_e    state, state_d;
  logic [SW-1:0] gnt, gnt_d;
  logic [SW-1:0] last, last_d;
  logic [BW-1:0] beat, beat_d;

  logic [N-1:0]  elig;
  logic          slot_free;
  logic          g_elig;
  logic [B-1:0]  g_data;
  logic          pop;
  logic          pick_any;
  logic [SW-1:0] pick_idx;

  assign elig      = ~empty_i & ~mask_i;
  // A word being accepted this cycle frees the slot for a same-cycle load.
  assign slot_free = ~out_valid | out_ready;
  assign busy      = (state == ST_GRANT);

  rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_rr_pick (
    .req  (elig),
    .last (last),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    g_elig = 1'b0;
    g_data = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt == SW'(k)) begin
        g_elig = elig[k];
        g_data = r_data_i[k*B +: B];
      end
    end
  end

  // Empty lags a pop by one cycle, so after the final word the grant sees
  // g_elig = 0 and leaves without strobing rd_o into an empty FIFO.
  assign pop = busy & g_elig & slot_free;

  always_comb begin
    rd_o = '0;
    for (int k = 0; k < N; k++) begin
      rd_o[k] = pop & (gnt == SW'(k));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      gnt   <= '0;
      last  <= LAST_RST;
      beat  <= '0;
    end else begin
      state <= state_d;
      gnt   <= gnt_d;
      last  <= last_d;
      beat  <= beat_d;
    end
  end

  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    last_d  = last;
    beat_d  = beat;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_idx;
          beat_d  = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!g_elig) begin
          // Ran empty or masked mid-burst: give up the grant, no pop.
          state_d = ST_IDLE;
          last_d  = gnt;
          beat_d  = '0;
        end else if (pop) begin
          if (beat == BEAT_LAST) begin
            state_d = ST_IDLE;
            last_d  = gnt;
            beat_d  = '0;
          end else begin
            beat_d = beat + 1'b1;
          end
        end
        // Back-pressure stall: hold grant and beat.
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_data  <= g_data;
      out_src   <= gnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rr_drain_arb.sv
// ---------------------------------------------------------------------------
// tb_fifo_rr_drain_arb
// Directed and randomized bench for fifo_rr_drain_arb (N=4, B=8, BURST=4).
// FIFOs are modelled as queues; expected pop order comes from a count-based
// round-robin model and output words from per-source expected queues.
// ---------------------------------------------------------------------------
module tb_fifo_rr_drain_arb;

  localparam int N     = 4;
  localparam int B     = 8;
  localparam int BURST = 4;
  localparam int SW    = 2;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   empty_i;
  logic [N*B-1:0] r_data_i;
  logic [N-1:0]   mask_i;
  logic [N-1:0]   rd_o;
  logic [B-1:0]   out_data;
  logic [SW-1:0]  out_src;
  logic           out_valid;
  logic           out_ready;
  logic           busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [B-1:0] fq [N][$];
  int           exp_q [N][$];
  int           exp_src [$];
  int           pop_src_log [$];
  int           pop_cyc [$];
  int           fill_cnt [N];
  int           cyc        = 0;
  int           pend_pop   = -1;
  int           accepted   = 0;
  int           model_last = N - 1;
  int           mon_e;
  bit           chk_order  = 1'b0;

  always #5 clk = ~clk;

  fifo_rr_drain_arb #(
    .N     (N),
    .B     (B),
    .BURST (BURST)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .empty_i   (empty_i),
    .r_data_i  (r_data_i),
    .mask_i    (mask_i),
    .rd_o      (rd_o),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int k = 0; k < N; k++) begin
      empty_i[k]          = (fq[k].size() == 0);
      r_data_i[k*B +: B]  = (fq[k].size() != 0) ? fq[k][0] : '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_all();
    for (int k = 0; k < N; k++) begin
      fq[k].delete();
      exp_q[k].delete();
    end
    exp_src.delete();
    refresh();
  endtask

  task automatic load_fifo(input int k, input int n);
    logic [B-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = B'($urandom);
      fq[k].push_back(w);
      exp_q[k].push_back(int'(w));
    end
    refresh();
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < N; k++) begin
      if (fq[k].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int sb_left();
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += exp_q[k].size();
    return s;
  endfunction

  task automatic wait_drain(input string tag, input int max_cyc, input bit rnd);
    int n;
    n = 0;
    while ((!all_empty() || out_valid || busy) && n < max_cyc) begin
      tick();
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    check(tag, 32'(n < max_cyc), 32'd1);
    out_ready = 1'b1;
  endtask

  // Round-robin by FIFO occupancy: starting after the previous grant, take
  // the next non-empty FIFO and pop min(BURST, count) words from it.
  task automatic predict_round();
    int c [N];
    int found;
    int n;
    for (int k = 0; k < N; k++) c[k] = fill_cnt[k];
    while (1) begin
      found = -1;
      for (int s = 1; s <= N; s++) begin
        if (found < 0 && c[(model_last + s) % N] > 0) found = (model_last + s) % N;
      end
      if (found < 0) break;
      n = (c[found] < BURST) ? c[found] : BURST;
      for (int i = 0; i < n; i++) exp_src.push_back(found);
      c[found] -= n;
      model_last = found;
    end
  endtask

  // FIFO model: apply the pop captured on the preceding falling edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (pend_pop >= 0) begin
      fq[pend_pop].delete(0);
      pend_pop = -1;
    end
    refresh();
  end

  // Monitor: pop legality, pop order, and word-level scoreboard.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      check("rd_onehot", 32'($onehot0(rd_o)), 32'd1);
      check("rd_legal", 32'(rd_o & (empty_i | mask_i)), 32'd0);
      pend_pop = -1;
      for (int k = 0; k < N; k++) if (rd_o[k]) pend_pop = k;
      if (pend_pop >= 0) begin
        pop_src_log.push_back(pend_pop);
        pop_cyc.push_back(cyc);
        if (chk_order) begin
          mon_e = (exp_src.size() > 0) ? exp_src.pop_front() : -1;
          check("pop_order", pend_pop, mon_e);
        end
      end
      if (out_valid && out_ready) begin
        accepted++;
        mon_e = (exp_q[out_src].size() > 0) ? exp_q[out_src].pop_front() : -1;
        check("out_word", 32'(out_data), mon_e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int acc0;
    int n;
    int total;
    logic [B-1:0] wv [$];
    int g [$];
    int t3_src [12];
    int t3_gap [11];
    t3_src = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
    t3_gap = '{1, 1, 1, 2, 1, 1, 1, 2, 1, 3, 1};

    reset_n   = 1'b0;
    out_ready = 1'b1;
    mask_i    = '0;
    refresh();
    repeat (2) @(posedge clk);
    #2;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_src", 32'(out_src), 32'd0);
    check("rst_rd", 32'(rd_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;

    // 1. reset mid-burst, then idle with everything empty
    load_fifo(0, 6);
    base = pop_src_log.size();
    n = 0;
    while (pop_src_log.size() - base < 2 && n < 20) begin
      tick();
      n++;
    end
    check("t1_pop_bound", 32'(n < 20), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t1_async_valid", 32'(out_valid), 32'd0);
    check("t1_async_rd", 32'(rd_o), 32'd0);
    check("t1_async_busy", 32'(busy), 32'd0);
    tick();
    check("t1_edge_valid", 32'(out_valid), 32'd0);
    check("t1_edge_rd", 32'(rd_o), 32'd0);
    check("t1_edge_busy", 32'(busy), 32'd0);
    clear_all();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t1_idle_busy", 32'(busy), 32'd0);
      check("t1_idle_rd", 32'(rd_o), 32'd0);
    end

    // 2. single source, three words in FIFO2
    load_fifo(2, 3);
    wv = fq[2];
    check("t2_arb_rd", 32'(rd_o), 32'd0);
    check("t2_arb_busy", 32'(busy), 32'd0);
    tick();
    check("t2_g_busy", 32'(busy), 32'd1);
    check("t2_g_rd0", 32'(rd_o), 32'h4);
    check("t2_g_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_data", 32'(out_data), 32'(wv[i]));
      check("t2_src", 32'(out_src), 32'd2);
      check("t2_valid", 32'(out_valid), 32'd1);
      check("t2_rd", 32'(rd_o), (i < 2) ? 32'h4 : 32'h0);
    end
    check("t2_exit_busy", 32'(busy), 32'd1);
    tick();
    check("t2_idle_busy", 32'(busy), 32'd0);
    check("t2_idle_valid", 32'(out_valid), 32'd0);

    // 3. burst limit with two sources of six words each
    base = pop_src_log.size();
    load_fifo(0, 6);
    load_fifo(1, 6);
    wait_drain("t3_drain", 200, 1'b0);
    check("t3_count", pop_src_log.size() - base, 32'd12);
    for (int i = 0; i < 12 && base + i < pop_src_log.size(); i++) begin
      check("t3_src", pop_src_log[base + i], t3_src[i]);
    end
    for (int i = 0; i < 11 && base + i + 1 < pop_cyc.size(); i++) begin
      check("t3_gap", pop_cyc[base + i + 1] - pop_cyc[base + i], t3_gap[i]);
    end

    // 4. back-pressure after the first word
    base = pop_src_log.size();
    acc0 = accepted;
    load_fifo(1, 5);
    wv = fq[1];
    tick();
    check("t4_rd0", 32'(rd_o), 32'h2);
    tick();
    check("t4_first", 32'(out_data), 32'(wv[0]));
    out_ready = 1'b0;
    #1;
    check("t4_stall_rd", 32'(rd_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_data", 32'(out_data), 32'(wv[0]));
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_rd", 32'(rd_o), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("t4_resume_rd", 32'(rd_o), 32'h2);
    tick();
    check("t4_second", 32'(out_data), 32'(wv[1]));
    wait_drain("t4_drain", 100, 1'b0);
    check("t4_accept", accepted - acc0, 32'd5);
    check("t4_pops", pop_src_log.size() - base, 32'd5);
    if (pop_cyc.size() - base == 5) begin
      check("t4_gap_stall", pop_cyc[base + 1] - pop_cyc[base], 32'd6);
      check("t4_gap_b2", pop_cyc[base + 2] - pop_cyc[base + 1], 32'd1);
      check("t4_gap_b3", pop_cyc[base + 3] - pop_cyc[base + 2], 32'd1);
      check("t4_gap_regrant", pop_cyc[base + 4] - pop_cyc[base + 3], 32'd2);
    end

    // 5. mask FIFO1 during its second beat
    acc0 = accepted;
    load_fifo(1, 4);
    wv = fq[1];
    tick();
    check("t5_rd1", 32'(rd_o), 32'h2);
    tick();
    check("t5_w0", 32'(out_data), 32'(wv[0]));
    check("t5_w0_src", 32'(out_src), 32'd1);
    load_fifo(2, 2);
    mask_i = 4'b0010;
    #1;
    check("t5_mask_rd", 32'(rd_o), 32'd0);
    tick();
    check("t5_exit_busy", 32'(busy), 32'd0);
    tick();
    check("t5_next_busy", 32'(busy), 32'd1);
    check("t5_next_rd", 32'(rd_o), 32'h4);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t5_masked", 32'(rd_o[1]), 32'd0);
    end
    check("t5_park_busy", 32'(busy), 32'd0);
    mask_i = '0;
    wait_drain("t5_drain", 100, 1'b0);
    check("t5_accept", accepted - acc0, 32'd6);
    check("t5_sb_left", sb_left(), 32'd0);

    // 6. fairness / wrap with random fill and random back-pressure
    reset_n = 1'b0;
    tick();
    clear_all();
    reset_n = 1'b1;
    model_last = N - 1;
    for (int r = 0; r < 3; r++) begin
      base  = pop_src_log.size();
      acc0  = accepted;
      total = 0;
      for (int k = 0; k < N; k++) begin
        fill_cnt[k] = (r == 0) ? $urandom_range(5, 10) : $urandom_range(0, 9);
        total += fill_cnt[k];
        load_fifo(k, fill_cnt[k]);
      end
      exp_src.delete();
      predict_round();
      chk_order = 1'b1;
      wait_drain("t6_drain", 3000, 1'b1);
      chk_order = 1'b0;
      check("t6_order_left", exp_src.size(), 32'd0);
      check("t6_accept", accepted - acc0, total);
      check("t6_sb_left", sb_left(), 32'd0);
      if (r == 0) begin
        g.delete();
        for (int i = base; i < pop_src_log.size(); i++) begin
          if (g.size() == 0 || g[g.size() - 1] != pop_src_log[i]) g.push_back(pop_src_log[i]);
        end
        check("t6_grants", 32'(g.size() >= 5), 32'd1);
        for (int i = 0; i < 5 && i < g.size(); i++) begin
          check("t6_grant_seq", g[i], i % N);
        end
      end
      repeat (3) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
